// File: rtl/joy_db15_tx_if.sv
// DB15 reader-to-adapter serial bus: the reader strobes load/clock, the adapter returns data.
interface joy_db15_tx_if;
    logic JOY_LOAD;
    logic JOY_CLK;
    logic JOY_DATA;

    modport master (output JOY_LOAD, output JOY_CLK, input JOY_DATA);
    modport slave  (input JOY_LOAD, input JOY_CLK, output JOY_DATA);
endinterface

// File: rtl/joy_db15_tx.sv
// DB15 dual-pad shift-register adapter: continuous parallel load while JOY_LOAD is low,
// then serialises {joystick2, joystick1} LSB-first on synchronised JOY_CLK rising edges.
module joy_db15_tx #(
    parameter int SYNC_STAGES = 2,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                I_RESETn,
    input  logic [15:0]         joystick1,
    input  logic [15:0]         joystick2,
    joy_db15_tx_if.slave        db15,
    output logic [5:0]          bit_cnt,
    output logic                frame_done,
    output logic                load_seen
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] load_sync;
    logic                   clk_hist;
    logic                   load_hist;
    logic [31:0]            shift_reg;
    logic [31:0]            frame;
    logic [31:0]            line;
    logic                   clk_s;
    logic                   load_s;
    logic                   clk_rise;

    assign frame    = {joystick2, joystick1};
    assign line     = ACTIVE_LOW ? ~frame : frame;
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign load_s   = load_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_hist;

    // Decoded straight from flops so the pulse lands on the cycle the frame freezes.
    assign load_seen     = load_s & ~load_hist;
    assign db15.JOY_DATA = shift_reg[0];

    // Everything resets to idle line levels so reset release cannot fake an edge.
    always_ff @(posedge clk or negedge I_RESETn) begin
        if (!I_RESETn) begin
            clk_sync   <= '1;
            load_sync  <= '1;
            clk_hist   <= 1'b1;
            load_hist  <= 1'b1;
            shift_reg  <= '1;
            bit_cnt    <= 6'd0;
            frame_done <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], db15.JOY_CLK};
            load_sync  <= {load_sync[SYNC_STAGES-2:0], db15.JOY_LOAD};
            clk_hist   <= clk_s;
            load_hist  <= load_s;
            frame_done <= 1'b0;
            if (!load_s) begin
                // Load dominates: shift edges seen while loading are discarded.
                shift_reg <= line;
                bit_cnt   <= 6'd0;
            end else if (clk_rise) begin
                shift_reg <= {1'b1, shift_reg[31:1]};
                if (bit_cnt != 6'd32) begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
                if (bit_cnt == 6'd31) begin
                    frame_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed and randomised checks of the DB15 adapter model, reader side driven at 4 clk per shift.
module tb_joy_db15_tx;

    logic        clk;
    logic        I_RESETn;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic [5:0]  bit_cnt;
    logic        frame_done;
    logic        load_seen;

    joy_db15_tx_if bus ();

    joy_db15_tx dut (
        .clk        (clk),
        .I_RESETn   (I_RESETn),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .db15       (bus.slave),
        .bit_cnt    (bit_cnt),
        .frame_done (frame_done),
        .load_seen  (load_seen)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fd_pulses;
    int ls_pulses;

    typedef struct {
        logic [15:0] j1;
        logic [15:0] j2;
        logic [31:0] exp_stream;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) fd_pulses++;
            if (load_seen === 1'b1) ls_pulses++;
        end
    endtask

    task automatic do_load();
        bus.JOY_LOAD = 1'b0;
        wait_neg(4);
        bus.JOY_LOAD = 1'b1;
        ls_pulses = 0;
        wait_neg(5);
    endtask

    task automatic shift_bit(output logic b);
        b = bus.JOY_DATA;
        bus.JOY_CLK = 1'b1;
        wait_neg(2);
        bus.JOY_CLK = 1'b0;
        wait_neg(2);
    endtask

    task automatic shift_n(input int n, output logic [31:0] word);
        logic b;
        word = '0;
        for (int i = 0; i < n; i++) begin
            shift_bit(b);
            word[i] = b;
        end
    endtask

    logic [31:0] word;
    logic [15:0] vals[5];
    logic [15:0] r1, r2;

    initial begin
        vecs[0] = '{16'h0001, 16'h0000, 32'hFFFF_FFFE};
        vecs[1] = '{16'h0000, 16'h8000, 32'h7FFF_FFFF};
        vecs[2] = '{16'hA5A5, 16'h0F0F, 32'hF0F0_5A5A};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 32'h0000_0000};
        vecs[4] = '{16'h1234, 16'hABCD, 32'h5432_EDCB};

        fd_pulses    = 0;
        ls_pulses    = 0;
        I_RESETn     = 1'b0;
        joystick1    = 16'h0000;
        joystick2    = 16'h0000;
        bus.JOY_LOAD = 1'b1;
        bus.JOY_CLK  = 1'b0;
        wait_neg(3);
        chk("rst_data", {31'd0, bus.JOY_DATA}, 32'd1);
        chk("rst_bit_cnt", {26'd0, bit_cnt}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_load_seen", {31'd0, load_seen}, 32'd0);
        I_RESETn = 1'b1;
        wait_neg(4);
        chk("post_rst_load_seen_cnt", ls_pulses, 0);

        // Table-driven full frames
        for (int v = 0; v < 5; v++) begin
            joystick1 = vecs[v].j1;
            joystick2 = vecs[v].j2;
            do_load();
            chk($sformatf("vec%0d_load_seen", v), ls_pulses, 1);
            fd_pulses = 0;
            shift_n(32, word);
            chk($sformatf("vec%0d_stream", v), word, vecs[v].exp_stream);
            chk($sformatf("vec%0d_frame_done", v), fd_pulses, 1);
            chk($sformatf("vec%0d_bit_cnt", v), {26'd0, bit_cnt}, 32'd32);
        end

        // Saturation: three more shifts after the frame
        fd_pulses = 0;
        shift_n(3, word);
        chk("sat_bit_cnt", {26'd0, bit_cnt}, 32'd32);
        chk("sat_data_bits", word, 32'h7);
        chk("sat_data", {31'd0, bus.JOY_DATA}, 32'd1);
        chk("sat_no_frame_done", fd_pulses, 0);

        // Load held low: shift edges ignored, data tracks ~joystick1[0] one cycle later
        vals[0] = 16'h0001; vals[1] = 16'h0000; vals[2] = 16'h0001;
        vals[3] = 16'h0002; vals[4] = 16'h0003;
        bus.JOY_LOAD = 1'b0;
        wait_neg(4);
        for (int i = 0; i < 5; i++) begin
            joystick1 = vals[i];
            wait_neg(1);
            chk($sformatf("track%0d_data", i), {31'd0, bus.JOY_DATA}, {31'd0, ~vals[i][0]});
            bus.JOY_CLK = 1'b1;
            wait_neg(2);
            bus.JOY_CLK = 1'b0;
            wait_neg(1);
            chk($sformatf("track%0d_bit_cnt", i), {26'd0, bit_cnt}, 32'd0);
        end
        bus.JOY_LOAD = 1'b1;
        wait_neg(5);

        // Inputs changed after release do not disturb the frozen frame
        joystick1 = 16'h0000;
        joystick2 = 16'h0000;
        do_load();
        joystick1 = 16'hFFFF;
        shift_n(16, word);
        chk("frozen_frame", word, 32'h0000_FFFF);
        shift_n(16, word);

        // Load fall and shift rise arriving together: load only
        joystick1 = 16'h0001;
        joystick2 = 16'h0000;
        do_load();
        shift_n(5, word);
        chk("pre_sim_bit_cnt", {26'd0, bit_cnt}, 32'd5);
        bus.JOY_LOAD = 1'b0;
        bus.JOY_CLK  = 1'b1;
        wait_neg(4);
        chk("sim_bit_cnt", {26'd0, bit_cnt}, 32'd0);
        chk("sim_data", {31'd0, bus.JOY_DATA}, 32'd0);
        bus.JOY_LOAD = 1'b1;
        wait_neg(4);
        chk("sim_release_bit_cnt", {26'd0, bit_cnt}, 32'd0);
        bus.JOY_CLK = 1'b0;
        wait_neg(2);
        shift_n(2, word);
        chk("sim_first_bits", word, 32'h2);
        shift_n(30, word);

        // Reset mid-frame aborts asynchronously, then shifts without load give ones
        joystick1 = 16'h0000;
        joystick2 = 16'h0000;
        do_load();
        shift_n(10, word);
        chk("pre_rst_bits", word, 32'h3FF);
        I_RESETn = 1'b0;
        #1;
        chk("async_rst_data", {31'd0, bus.JOY_DATA}, 32'd1);
        chk("async_rst_bit_cnt", {26'd0, bit_cnt}, 32'd0);
        wait_neg(2);
        I_RESETn = 1'b1;
        wait_neg(4);
        fd_pulses = 0;
        shift_n(31, word);
        chk("noload_bits", word, 32'h7FFF_FFFF);
        chk("noload_no_frame_done", fd_pulses, 0);
        shift_n(1, word);
        chk("noload_last_bit", word, 32'h1);
        chk("noload_frame_done", fd_pulses, 1);

        // Random pads, data changed after release each frame
        for (int f = 0; f < 300; f++) begin
            r1 = 16'($urandom);
            r2 = 16'($urandom);
            joystick1 = r1;
            joystick2 = r2;
            do_load();
            joystick1 = 16'($urandom);
            joystick2 = 16'($urandom);
            shift_n(32, word);
            chk($sformatf("rand%0d_stream", f), word, ~{r2, r1});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
